popcount_sequencer: RTL and testbench

POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

---
 rtl/popcount_sequencer.sv | 131 +++++++++++++
 tb/tb_popcount_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/popcount_sequencer.sv
// Sequential popcount: feeds a captured word one nibble per cycle through a two-stage
// nibble-count pipeline into an accumulator, then holds the result until it is taken.
module popcount_sequencer #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic             i_INVERSE,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [CW-1:0]    o_COUNT,
  output logic             o_BUSY
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned NW = $clog2(N);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("popcount_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [NW-1:0]    nib_q, nib_d;
  logic             drain_q, drain_d;
  logic             inv_q, inv_d;
  logic [2:0]       s1_q, s1_d;
  logic             s1_vld_q, s1_vld_d;
  logic [2:0]       s2_q, s2_d;
  logic             s2_vld_q, s2_vld_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;

  function automatic logic [2:0] nib_pop(input logic [3:0] n);
    return 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
  endfunction

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    nib_d    = nib_q;
    drain_d  = drain_q;
    inv_d    = inv_q;
    count_d  = count_q;
    valid_d  = valid_q;
    s1_d     = nib_pop(shift_q[3:0]);
    s1_vld_d = 1'b0;
    s2_d     = s1_q;
    s2_vld_d = s1_vld_q;
    acc_d    = acc_q + (s2_vld_q ? CW'(s2_q) : '0);

    unique case (state_q)
      StIdle: begin
        if (i_VALID) begin
          state_d = StFeed;
          shift_d = i_DATA;
          inv_d   = i_INVERSE;
          nib_d   = '0;
          acc_d   = '0;
        end
      end
      StFeed: begin
        s1_vld_d = 1'b1;
        shift_d  = shift_q >> 4;
        nib_d    = nib_q + 1'b1;
        if (nib_q == NW'(N - 1)) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        // Second drain cycle: acc_d already includes the last nibble count.
        if (drain_q) begin
          state_d = StDone;
          valid_d = 1'b1;
          count_d = inv_q ? (CW'(WIDTH) - acc_d) : acc_d;
        end
      end
      StDone: begin
        if (i_READY) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      nib_q    <= '0;
      drain_q  <= 1'b0;
      inv_q    <= 1'b0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      nib_q    <= nib_d;
      drain_q  <= drain_d;
      inv_q    <= inv_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_q     <= s2_d;
      s2_vld_q <= s2_vld_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign o_READY = (state_q == StIdle);
  assign o_BUSY  = (state_q != StIdle);
  assign o_VALID = valid_q;
  assign o_COUNT = count_q;

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: directed cases, backpressure, reset and
// randomized traffic scored against a plain arithmetic popcount model.
module tb_popcount_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data;
  logic             inverse;
  logic             out_valid;
  logic             in_ready;
  logic [CW-1:0]    count;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  popcount_sequencer #(.WIDTH(WIDTH)) dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_VALID  (in_valid),
    .o_READY  (out_ready),
    .i_DATA   (data),
    .i_INVERSE(inverse),
    .o_VALID  (out_valid),
    .i_READY  (in_ready),
    .o_COUNT  (count),
    .o_BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_count(input logic [WIDTH-1:0] d, input logic inv);
    return inv ? (WIDTH - $countones(d)) : $countones(d);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One transaction with i_READY low; the result is held for `hold` cycles before release.
  task automatic do_word(input logic [WIDTH-1:0] d, input logic inv, input int hold);
    int exp;
    exp = ref_count(d, inv);
    check("pre_ready", out_ready, 1);
    in_valid = 1'b1;
    data     = d;
    inverse  = inv;
    tick();                                  // accept edge counts as edge 1
    in_valid = 1'b0;
    data     = $urandom;
    inverse  = 1'($urandom);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", out_ready, 0);
    for (int e = 2; e <= N + 2; e++) begin
      tick();
      if (out_valid !== 1'b0) check("valid_early", out_valid, 0);
    end
    tick();                                  // edge N+3
    check("valid_on_time", out_valid, 1);
    check("count", count, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 2);
      data     = 32'h1234_5678;
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_count", count, exp);
      check("hold_ready", out_ready, 0);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", out_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    int exp_q[$];
    int acc_q[$];
    int last_acc;
    int results;
    int words;
    logic obs_ready, obs_valid;
    logic [CW-1:0] obs_count;
    logic hs;

    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; data = '0; inverse = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ready", out_ready, 1);
      check("idle_valid", out_valid, 0);
      check("idle_count", count, 0);
      check("idle_busy", busy, 0);
    end

    do_word(32'hFFFF_FFFF, 1'b0, 0);
    do_word(32'h8000_0001, 1'b0, 0);
    do_word(32'h8000_0001, 1'b1, 0);
    do_word(32'h0000_0000, 1'b1, 0);
    do_word(32'h0F0F_0F0F, 1'b0, 6);
    for (int i = 0; i < 3; i++) do_word($urandom, 1'($urandom), i);

    // Reset while the third nibble is being issued.
    in_valid = 1'b1; data = 32'hFFFF_FFFF; inverse = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ready", out_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    do_word(32'h0000_0003, 1'b0, 0);

    // Back-to-back with both handshakes held high.
    in_valid = 1'b1; in_ready = 1'b1;
    results = 0; last_acc = -1;
    for (int c = 0; c < 100 && results < 4; c++) begin
      data = $urandom; inverse = 1'($urandom);
      obs_ready = out_ready; obs_valid = out_valid; obs_count = count;
      tick();
      if (obs_ready) begin
        exp_q.push_back(ref_count(data, inverse));
        if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, N + 4);
        last_acc = cyc;
      end
      if (obs_valid) begin
        if (exp_q.size() > 0) check("b2b_count", obs_count, exp_q.pop_front());
        results++;
      end
    end
    in_valid = 1'b0; in_ready = 1'b0;
    check("b2b_results", results, 4);
    exp_q.delete();
    tick();

    // Randomized traffic with reset injection.
    words = 0;
    for (int c = 0; c < 60000 && words < 1000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = 1'($urandom);
      in_ready = 1'($urandom);
      data     = $urandom;
      inverse  = 1'($urandom);
      obs_ready = out_ready; obs_valid = out_valid; obs_count = count;
      tick();
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        check("rnd_rst_valid", out_valid, 0);
      end else begin
        hs = obs_valid && in_ready;
        if (in_valid && obs_ready) begin
          exp_q.push_back(ref_count(data, inverse));
          acc_q.push_back(cyc);
          words++;
        end
        if (!obs_valid && out_valid) begin
          check("rnd_pending", acc_q.size() > 0 ? 1 : 0, 1);
          if (acc_q.size() > 0) check("rnd_latency", cyc - acc_q.pop_front(), N + 2);
        end
        if (hs) begin
          check("rnd_pending_hs", exp_q.size() > 0 ? 1 : 0, 1);
          if (exp_q.size() > 0) check("rnd_count", obs_count, exp_q.pop_front());
        end else if (obs_valid) begin
          check("rnd_valid_hold", out_valid, 1);
          check("rnd_count_hold", count, obs_count);
        end
      end
    end
    rst = 1'b0;
    check("rnd_words", words >= 1000 ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
